// File: rtl/serial_deserializer_if.sv
// Handshake bundle between the serial deserializer (master) and its environment (slave).
// parity_err exists only when SERIAL_DESERIALIZER_PARITY_EN is defined.
interface serial_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic             parity_err;

    modport master (
        input  sin, sin_valid, dout_ready,
        output dout, dout_valid, overrun, parity_err
    );
    modport slave (
        output sin, sin_valid, dout_ready,
        input  dout, dout_valid, overrun, parity_err
    );
`else
    modport master (
        input  sin, sin_valid, dout_ready,
        output dout, dout_valid, overrun
    );
    modport slave (
        output sin, sin_valid, dout_ready,
        input  dout, dout_valid, overrun
    );
`endif
endinterface

// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel converter with a one-word valid/ready holding register.
// Optional even-parity bit per frame: define SERIAL_DESERIALIZER_PARITY_EN.
module serial_deserializer #(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_deserializer_if.master bus
);
    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sh_p0;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] dout_p1;
    logic             vld_p1;
    logic             overrun_p1;
    logic             accept;

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic parity_err_p1;

    function automatic logic parity_mismatch(input logic [WIDTH-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`endif

    assign sh_next = {bus.sin, sh_p0[WIDTH-1:1]};
    // A finished word may load when the holder is empty or is being drained on this edge.
    assign accept  = !vld_p1 || bus.dout_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sh_p0      <= '0;
            dout_p1    <= '0;
            vld_p1     <= 1'b0;
            overrun_p1 <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            parity_err_p1 <= 1'b0;
`endif
        end else begin
            overrun_p1 <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            parity_err_p1 <= 1'b0;
`endif
            if (vld_p1 && bus.dout_ready)
                vld_p1 <= 1'b0;

            // p0: shift stage; p1: holding register, loaded on frame completion
            if (bus.sin_valid) begin
                case (state)
                    IDLE, SHIFT: begin
                        sh_p0 <= sh_next;
                        if (cnt == LAST_DATA) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                            cnt   <= CNT_W'(WIDTH);
                            state <= PAR;
`else
                            cnt   <= '0;
                            state <= IDLE;
                            if (accept) begin
                                dout_p1 <= sh_next;
                                vld_p1  <= 1'b1;
                            end else begin
                                overrun_p1 <= 1'b1;
                            end
`endif
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= SHIFT;
                        end
                    end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                    PAR: begin
                        // The parity bit is checked against the data, never shifted in.
                        cnt   <= '0;
                        state <= IDLE;
                        if (accept) begin
                            dout_p1       <= sh_p0;
                            vld_p1        <= 1'b1;
                            parity_err_p1 <= parity_mismatch(sh_p0, bus.sin);
                        end else begin
                            overrun_p1 <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.dout       = dout_p1;
    assign bus.dout_valid = vld_p1;
    assign bus.overrun    = overrun_p1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    assign bus.parity_err = parity_err_p1;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (WIDTH=4) with a queue scoreboard of expected words.
// Parity checks run only when SERIAL_DESERIALIZER_PARITY_EN is defined.
module tb_serial_deserializer;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [3:0] exp_q[$];

    serial_deserializer_if #(.WIDTH(4)) bus ();

    serial_deserializer #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Words are compared when consumed; sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {28'd0, bus.dout}, 32'hFFFF_FFFF);
            end else begin
                check("sb_word", {28'd0, bus.dout}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic b);
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sin_valid = 1'b0;
    endtask

    task automatic send_last(input logic b, input logic [3:0] w);
        send(b);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        send(^w);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] w;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.dout_ready = 1'b0;

        #2;
        check("rst_dout", {28'd0, bus.dout}, 32'd0);
        check("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        #10 rst_n = 1'b1;
        idle(1);

        // back-to-back frame
        bus.dout_ready = 1'b1;
        exp_q.push_back(4'b1101);
        send(1'b1); send(1'b0); send(1'b1);
        check("b2b_no_early_valid", {31'd0, bus.dout_valid}, 32'd0);
        send_last(1'b1, 4'b1101);
        check("b2b_valid", {31'd0, bus.dout_valid}, 32'd1);
        check("b2b_overrun", {31'd0, bus.overrun}, 32'd0);
        idle(1);
        check("b2b_valid_one_cycle", {31'd0, bus.dout_valid}, 32'd0);

        // gaps in sin_valid do not advance the frame
        exp_q.push_back(4'b1101);
        send(1'b1); send(1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("gap_no_valid", {31'd0, bus.dout_valid}, 32'd0);
        end
        send(1'b1);
        check("gap_no_valid_bit2", {31'd0, bus.dout_valid}, 32'd0);
        send_last(1'b1, 4'b1101);
        check("gap_valid", {31'd0, bus.dout_valid}, 32'd1);
        idle(1);

        // backpressure: second word dropped
        bus.dout_ready = 1'b0;
        exp_q.push_back(4'b1101);
        send(1'b1); send(1'b0); send(1'b1);
        send_last(1'b1, 4'b1101);
        check("bp_valid", {31'd0, bus.dout_valid}, 32'd1);
        check("bp_dout", {28'd0, bus.dout}, 32'hD);
        send(1'b1); send(1'b1); send(1'b0);
        check("bp_no_early_overrun", {31'd0, bus.overrun}, 32'd0);
        send_last(1'b0, 4'b0011);
        check("bp_overrun", {31'd0, bus.overrun}, 32'd1);
        check("bp_dout_held", {28'd0, bus.dout}, 32'hD);
        check("bp_valid_held", {31'd0, bus.dout_valid}, 32'd1);
        idle(1);
        check("bp_overrun_pulse", {31'd0, bus.overrun}, 32'd0);
        check("bp_dout_still", {28'd0, bus.dout}, 32'hD);

        // simultaneous drain and fill
        exp_q.push_back(4'b0110);
        send(1'b0); send(1'b1); send(1'b1);
        bus.dout_ready = 1'b1;
        send_last(1'b0, 4'b0110);
        check("df_valid", {31'd0, bus.dout_valid}, 32'd1);
        check("df_dout", {28'd0, bus.dout}, 32'h6);
        check("df_overrun", {31'd0, bus.overrun}, 32'd0);
        idle(1);
        check("df_drained", {31'd0, bus.dout_valid}, 32'd0);

        // asynchronous reset mid-frame
        bus.dout_ready = 1'b0;
        send(1'b1); send(1'b1); send(1'b1);
        send_last(1'b1, 4'b1111);
        check("mr_pending", {31'd0, bus.dout_valid}, 32'd1);
        send(1'b1); send(1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mr_dout_zero", {28'd0, bus.dout}, 32'd0);
        check("mr_valid_zero", {31'd0, bus.dout_valid}, 32'd0);
        check("mr_overrun_zero", {31'd0, bus.overrun}, 32'd0);
        #1 rst_n = 1'b1;
        idle(1);
        bus.dout_ready = 1'b1;
        exp_q.push_back(4'b0110);
        send(1'b0); send(1'b1); send(1'b1);
        send_last(1'b0, 4'b0110);
        check("mr_new_valid", {31'd0, bus.dout_valid}, 32'd1);
        check("mr_new_dout", {28'd0, bus.dout}, 32'h6);
        idle(1);

        // random back-to-back words
        for (int k = 0; k < 3; k++) begin
            w = 4'($urandom_range(0, 15));
            exp_q.push_back(w);
            send(w[0]); send(w[1]); send(w[2]);
            send_last(w[3], w);
            check("rnd_valid", {31'd0, bus.dout_valid}, 32'd1);
        end
        idle(2);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
        exp_q.push_back(4'b1101);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b1);
        check("par_ok_valid", {31'd0, bus.dout_valid}, 32'd1);
        check("par_ok_err", {31'd0, bus.parity_err}, 32'd0);
        exp_q.push_back(4'b1101);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        check("par_bad_valid", {31'd0, bus.dout_valid}, 32'd1);
        check("par_bad_err", {31'd0, bus.parity_err}, 32'd1);
        idle(1);
        check("par_err_pulse", {31'd0, bus.parity_err}, 32'd0);
        idle(1);
`endif

        check("sb_all_consumed", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

- Receives a serial bit stream, one bit per qualified clock, and reassembles it into WIDTH-bit parallel words.
- Presents each completed word on a valid/ready output port backed by a one-word holding register.
- Acts as the receiving end of the serial shift chain: it converts the 1-bit line produced by the team's shift-register blocks back into parallel data for downstream logic.

## Interface
- WIDTH, 4, data bits per word; legal range 2..32.
- clk  input  1  system clock, all state changes on rising edge.
- rst_n  input  1  asynchronous reset, active-low; one clock domain only.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge when high; low cycles are gaps and do not advance the frame.
- dout  output  WIDTH  completed word; the first received bit is at dout[0].
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid && dout_ready.
- overrun  output  1  one-cycle pulse: a completed word was dropped because the holding register was full.
- parity_err  output  1  present only with SERIAL_DESERIALIZER_PARITY_EN; one-cycle pulse, see Configuration.

## Operation
- Shift register sh[WIDTH-1:0]: each sampled bit enters at the MSB and the register shifts right.
  - After WIDTH samples, the first bit sits at bit 0.
- Bit counter cnt: 0..WIDTH-1, or 0..WIDTH with parity enabled. It increments per sample and wraps to 0 on the final sample of a frame.
- FSM states:
  - IDLE (cnt==0): no partial frame.
  - SHIFT (0<cnt<WIDTH): collecting data bits.
  - PAR (cnt==WIDTH): parity only.
  - Transitions occur only on sampled bits. IDLE→SHIFT on the first sample. SHIFT→IDLE on the WIDTH-th sample, or SHIFT→PAR with parity enabled. PAR→IDLE on the parity sample.
- Frame completion, on the edge sampling the final bit:
  - The completed word is {sin, sh[WIDTH-1:1]}, which includes the current bit.
  - It loads the holding register if !dout_valid, or if dout_valid && dout_ready on the same edge (simultaneous drain and fill, no bubble).
  - Otherwise the word is discarded, overrun pulses, and the holding register and dout_valid are unchanged.
- Consumption: an edge with dout_valid && dout_ready and no simultaneous load clears dout_valid.
- dout is held stable while dout_valid is high and not consumed.
- Sampling is never stalled. Backpressure affects only the holding register.

## Timing
- Reset values: dout=0, dout_valid=0, overrun=0, parity_err=0, sh=0, cnt=0, FSM=IDLE. Reset takes effect immediately on rst_n falling, regardless of clk.
- Reset mid-frame discards the partial frame. The first sample after rst_n rises is bit 0 of a new frame.
- Latency: dout_valid rises in the cycle after the edge that samples the last frame bit.
- Throughput: one word every WIDTH cycles (WIDTH+1 with parity) with sin_valid held high and dout_ready high.
- Bit ordering is fixed LSB-first. There is no framing or resynchronisation other than reset.

## Configuration
- SERIAL_DESERIALIZER_PARITY_EN defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit.
  - On completion the word loads as usual. parity_err pulses on the same edge as the load when the XOR of the data bits differs from the parity bit.
  - On overrun the word is dropped and parity_err is not asserted.
  - The data word for the holding register is sh at completion, not including sin.
- Undefined:
  - Frames are WIDTH bits, the PAR state does not exist, and the parity_err port is absent.

## Test plan
- Back-to-back frame (WIDTH=4): sin = 1,0,1,1 with sin_valid high, dout_ready high → dout=4'b1101, dout_valid=1 for exactly one cycle after the 4th sampling edge, overrun=0.
- Gaps: same bits with sin_valid low for 3 cycles between bits 2 and 3 → dout=4'b1101, no early dout_valid.
- Backpressure: dout_ready=0, send 4'b1101 then 4'b0011 (bits 1,1,0,0) → dout stays 4'b1101, overrun pulses once on the 8th sample edge.
- Simultaneous drain/fill: first word pending, dout_ready=1 exactly on the edge completing word 2 → dout becomes word 2, dout_valid stays 1, overrun=0.
- Reset mid-frame: 2 bits sampled, pulse rst_n low between clock edges → all outputs 0 at once; next 4 bits 0,1,1,0 → dout=4'b0110.
- Parity (SERIAL_DESERIALIZER_PARITY_EN): bits 1,0,1,1 + parity 1 → dout=4'b1101, parity_err=0; with parity 0 → parity_err pulses for one cycle with dout_valid rising.
